// File: rtl/pwm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pwm_pkg
// Brief   : Shared channel state type and constant helpers for pwm_dt_multi.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      DEAD = 2'd1,
      HI   = 2'd2,
      LO   = 2'd3
   } pwm_state_t;

   function automatic logic [31:0] all_ones(input int unsigned w);
      return (32'h1 << w) - 32'h1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_dt_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pwm_dt_channel
// Brief   : One PWM channel: double-buffered duty, compare, dead-time FSM.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pwm_dt_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 11,
   parameter int DT_WIDTH = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_i,
   input  logic                load_i,
   input  logic                wrap_i,
   input  logic [WIDTH-1:0]    cnt_i,
   input  logic [WIDTH-1:0]    duty_i,
   input  logic [DT_WIDTH-1:0] dead_time_i,
   output logic                pwm_o,
   output logic                pwm_n_o
);

   localparam logic [WIDTH-1:0] c_DUTY_MAX = WIDTH'(all_ones(WIDTH));

   logic [WIDTH-1:0]    shadow_q;
   logic [WIDTH-1:0]    active_q;
   pwm_state_t          state_q, state_d;
   logic                target_q, target_d;
   logic [DT_WIDTH-1:0] dcnt_q, dcnt_d;
   logic                pwm_q, pwm_d;
   logic                pwm_n_q, pwm_n_d;
   logic                raw_on;
   logic                dt_zero;

   // A load on the wrap edge lands in shadow only; active takes the old shadow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (wrap_i) active_q <= shadow_q;
         if (load_i) shadow_q <= duty_i;
      end
   end

   assign raw_on  = (active_q == c_DUTY_MAX) || (active_q > cnt_i);
   assign dt_zero = (dead_time_i == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= OFF;
         target_q <= 1'b0;
         dcnt_q   <= '0;
         pwm_q    <= 1'b0;
         pwm_n_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         dcnt_q   <= dcnt_d;
         pwm_q    <= pwm_d;
         pwm_n_q  <= pwm_n_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      dcnt_d   = dcnt_q;
      if (!en_i) begin
         state_d = OFF;
      end else begin
         case (state_q)
            OFF: begin
               target_d = raw_on;
               dcnt_d   = dead_time_i;
               state_d  = dt_zero ? (raw_on ? HI : LO) : DEAD;
            end
            DEAD: begin
               if (raw_on != target_q) begin
                  target_d = raw_on;
                  dcnt_d   = dead_time_i;
                  if (dt_zero) state_d = raw_on ? HI : LO;
               end else if (dcnt_q <= DT_WIDTH'(1)) begin
                  // count reaches zero on this edge, so the dead window is exactly dead_time cycles
                  dcnt_d  = '0;
                  state_d = target_q ? HI : LO;
               end else begin
                  dcnt_d = dcnt_q - DT_WIDTH'(1);
               end
            end
            HI: begin
               if (!raw_on) begin
                  target_d = 1'b0;
                  dcnt_d   = dead_time_i;
                  state_d  = dt_zero ? LO : DEAD;
               end
            end
            LO: begin
               if (raw_on) begin
                  target_d = 1'b1;
                  dcnt_d   = dead_time_i;
                  state_d  = dt_zero ? HI : DEAD;
               end
            end
            default: state_d = OFF;
         endcase
      end
   end

   always_comb begin
      pwm_d   = (state_d == HI);
      pwm_n_d = (state_d == LO);
   end

   assign pwm_o   = pwm_q;
   assign pwm_n_o = pwm_n_q;

endmodule
`default_nettype wire

// File: rtl/pwm_dt_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pwm_dt_multi
// Brief   : Multi-channel PWM with shared period counter and dead-time pairs.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pwm_dt_multi
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 11,
   parameter int NCH      = 2,
   parameter int DT_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 load,
   input  logic [NCH*WIDTH-1:0] duty_in,
   input  logic [DT_WIDTH-1:0]  dead_time,
   output logic [NCH-1:0]       PWM_sig,
   output logic [NCH-1:0]       PWM_sig_n,
   output logic                 period_start
);

   localparam logic [WIDTH-1:0] c_CNT_MAX = WIDTH'(all_ones(WIDTH));

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             period_start_q, period_start_d;
   logic             wrap;

   assign wrap = en && (cnt_q == c_CNT_MAX);

   always_comb begin
      cnt_d          = en ? (cnt_q + WIDTH'(1)) : '0;
      period_start_d = en && (cnt_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign period_start = period_start_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      pwm_dt_channel #(
         .WIDTH    (WIDTH),
         .DT_WIDTH (DT_WIDTH)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .en_i        (en),
         .load_i      (load),
         .wrap_i      (wrap),
         .cnt_i       (cnt_q),
         .duty_i      (duty_in[i*WIDTH +: WIDTH]),
         .dead_time_i (dead_time),
         .pwm_o       (PWM_sig[i]),
         .pwm_n_o     (PWM_sig_n[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_dt_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_pwm_dt_multi
// Brief   : Directed self-checking bench for pwm_dt_multi (2 channels, 11 bit).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pwm_dt_multi;

   localparam int WIDTH    = 11;
   localparam int NCH      = 2;
   localparam int DT_WIDTH = 6;
   localparam int PER      = 2048;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 load;
   logic [NCH*WIDTH-1:0] duty_in;
   logic [DT_WIDTH-1:0]  dead_time;
   logic [NCH-1:0]       PWM_sig;
   logic [NCH-1:0]       PWM_sig_n;
   logic                 period_start;

   int n_cmp   = 0;
   int n_err   = 0;
   int overlap = 0;

   always #5 clk = ~clk;

   pwm_dt_multi #(
      .WIDTH    (WIDTH),
      .NCH      (NCH),
      .DT_WIDTH (DT_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .load         (load),
      .duty_in      (duty_in),
      .dead_time    (dead_time),
      .PWM_sig      (PWM_sig),
      .PWM_sig_n    (PWM_sig_n),
      .period_start (period_start)
   );

   always @(negedge clk) if ((PWM_sig & PWM_sig_n) != '0) overlap++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH*WIDTH-1:0] pack(input int d0, input int d1);
      return {WIDTH'(d1), WIDTH'(d0)};
   endfunction

   // One full period aligned to period_start; optional load strobe at cycle load_at.
   task automatic measure(input int load_at, input int d0, input int d1,
                          output int h0, output int l0, output int h1, output int l1);
      int t  = 0;
      int ps = 0;
      h0 = 0; l0 = 0; h1 = 0; l1 = 0;
      @(negedge clk);
      load = 1'b0;
      while (period_start !== 1'b1 && t < 3*PER) begin
         @(negedge clk);
         t++;
      end
      check("ps_wait", {31'd0, t < 3*PER}, 1);
      for (int c = 0; c < PER; c++) begin
         if (c > 0) @(negedge clk);
         if (c == load_at) begin
            duty_in = pack(d0, d1);
            load    = 1'b1;
         end else begin
            load = 1'b0;
         end
         h0 += PWM_sig[0]   ? 1 : 0;
         l0 += PWM_sig_n[0] ? 1 : 0;
         h1 += PWM_sig[1]   ? 1 : 0;
         l1 += PWM_sig_n[1] ? 1 : 0;
         ps += period_start ? 1 : 0;
      end
      check("ps_once", ps, 1);
   endtask

   initial begin
      int h0, l0, h1, l1, bad, n;
      rst = 1'b1; en = 1'b0; load = 1'b0; duty_in = '0; dead_time = '0;
      repeat (3) @(negedge clk);
      check("rst_pwm",   {30'd0, PWM_sig},   0);
      check("rst_pwm_n", {30'd0, PWM_sig_n}, 0);
      check("rst_ps",    {31'd0, period_start}, 0);
      rst = 1'b0;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dut.cnt_q != '0 || PWM_sig != '0 || PWM_sig_n != '0 || period_start) bad++;
      end
      check("idle", bad, 0);

      // 50% / 25% without dead time
      duty_in = pack(32'h400, 32'h200);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      en   = 1'b1;
      measure(-1, 0, 0, h0, l0, h1, l1);
      check("d50_h0", h0, 1024); check("d50_l0", l0, 1024);
      check("d25_h1", h1, 512);  check("d25_l1", l1, 1536);

      // dead time 5 on every edge
      dead_time = 6'd5;
      measure(-1, 0, 0, h0, l0, h1, l1);
      check("dt5_h0", h0, 1019); check("dt5_l0", l0, 1019);
      check("dt5_h1", h1, 507);  check("dt5_l1", l1, 1531);

      // double buffering
      dead_time = 6'd0;
      measure(32'h200, 32'h100, 32'h200, h0, l0, h1, l1);
      check("dbuf_keep_h0", h0, 1024);
      measure(PER-1, 32'h300, 32'h200, h0, l0, h1, l1);
      check("dbuf_new_h0", h0, 256); check("dbuf_new_l0", l0, 1792);
      measure(-1, 0, 0, h0, l0, h1, l1);
      check("wrapload_old_h0", h0, 256);
      measure(-1, 0, 0, h0, l0, h1, l1);
      check("wrapload_new_h0", h0, 768);
      check("indep_h1", h1, 512);

      // boundaries: 0% on ch0, 100% on ch1
      measure(10, 0, 32'h7FF, h0, l0, h1, l1);
      measure(-1, 0, 0, h0, l0, h1, l1);
      measure(-1, 0, 0, h0, l0, h1, l1);
      check("d0_h0", h0, 0);      check("d0_l0", l0, PER);
      check("d100_h1", h1, PER);  check("d100_l1", l1, 0);

      // en drop while ch1 is high, then re-enable with dead time
      check("pre_dis_hi", {31'd0, PWM_sig[1]}, 1);
      en = 1'b0;
      @(negedge clk);
      check("en_off_pwm",   {30'd0, PWM_sig},   0);
      check("en_off_pwm_n", {30'd0, PWM_sig_n}, 0);
      @(negedge clk);
      check("cnt_hold", {21'd0, dut.cnt_q}, 0);
      dead_time = 6'd5;
      en = 1'b1;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (PWM_sig[1]) break;
         if (!PWM_sig_n[1]) n++;
      end
      check("reen_dead", n, 5);
      check("reen_hi",   {31'd0, PWM_sig[1]},   1);
      check("reen_ch0_lo", {31'd0, PWM_sig_n[0]}, 1);

      // async reset while high, then again while in DEAD
      #2 rst = 1'b1;
      #1 check("rst_async_hi", {30'd0, PWM_sig}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("dead_both_lo", {28'd0, PWM_sig, PWM_sig_n}, 0);
      #2 rst = 1'b1;
      #1 check("rst_dead", {28'd0, PWM_sig, PWM_sig_n}, 0);
      @(negedge clk);
      rst = 1'b0;
      dead_time = 6'd0;
      measure(-1, 0, 0, h0, l0, h1, l1);
      check("post_rst_h0", h0, 0);  check("post_rst_l0", l0, PER);
      check("post_rst_h1", h1, 0);  check("post_rst_l1", l1, PER);

      check("never_both_hi", overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
